// File: rtl/dump_pkg.sv
// Shared types and default widths for the result_dump host reader.
//   state_t         : run/dump FSM encoding
//   DUMP_AW/DW/LW   : default address, data and length widths
package dump_pkg;

  localparam int DUMP_AW = 8;
  localparam int DUMP_DW = 8;
  localparam int DUMP_LW = DUMP_AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    DUMP,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/dump_out_reg.sv
// One-entry stream output register with valid/ready hold semantics.
// Used for both data beats and the optional checksum beat.
//   clk, reset     : clock, async active-high reset
//   load_i         : capture data_i/last_i and assert valid (wins over clr_i)
//   clr_i          : drop valid and last (beat has been consumed)
//   data_i, last_i : next beat contents
//   valid_o, data_o, last_o : registered stream outputs
module dump_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          last_q;

  // Nothing changes unless load or clear is asked for, so a stalled beat
  // holds its data and last flag by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/result_dump.sv
// Host-side run controller and data-memory reader for the single-cycle core.
// Pulses req on start, waits for the core's done level, then streams a window
// of data memory out over valid/ready.
// Optional feature macro: DUMP_CSUM_EN -- appends a modulo-2^DW sum beat that
// carries out_last instead of the final data word.
//   clk, reset            : clock, async active-high reset
//   start, start_addr, length : run command (accepted only in IDLE)
//   req / done            : one-cycle run request / core halted level
//   mem_addr / mem_dat    : registered read address / combinational read data
//   out_data/valid/ready/last : output stream
//   busy, finished        : not-idle level, one-cycle completion pulse
module result_dump
  import dump_pkg::*;
#(
  parameter int AW = DUMP_AW,
  parameter int DW = DUMP_DW,
  parameter int LW = DUMP_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] length,
  output logic          req,
  input  logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dat,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          finished
);

  localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic [LW-1:0] len_clamp;

  logic accept, xfer, slot_free, ld_data, last_word, rem_zero;
  logic          ld, clr, ld_last;
  logic [DW-1:0] ld_dat;

  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
  assign accept    = (state_q == IDLE) && start;
  assign xfer      = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign ld_data   = (state_q == DUMP) && slot_free;
  assign last_word = (rem_q == LW'(1));
  assign rem_zero  = (rem_q == '0);

`ifdef DUMP_CSUM_EN
  logic [DW-1:0] sum_q;
  logic          pend_q;   // checksum beat still to be loaded
  logic          ld_csum;
  assign ld_csum = (state_q == DRAIN) && pend_q && slot_free;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = REQ;
      REQ:       state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
`ifdef DUMP_CSUM_EN
          state_d = rem_zero ? DRAIN : DUMP;
`else
          state_d = rem_zero ? FIN : DUMP;
`endif
        end
      end
      DUMP:      if (ld_data && last_word) state_d = DRAIN;
      DRAIN: begin
`ifdef DUMP_CSUM_EN
        if (!pend_q && xfer) state_d = FIN;
`else
        if (xfer) state_d = FIN;
`endif
      end
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    req      = (state_q == REQ);
    busy     = (state_q != IDLE);
    finished = (state_q == FIN);
    clr      = (state_q == DRAIN) && xfer;
`ifdef DUMP_CSUM_EN
    ld       = ld_data || ld_csum;
    ld_dat   = ld_csum ? sum_q : mem_dat;
    ld_last  = ld_csum;
`else
    ld       = ld_data;
    ld_dat   = mem_dat;
    ld_last  = last_word;
`endif
  end

  // Address / remaining-word counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      addr_q <= start_addr;
      rem_q  <= len_clamp;
    end else if (ld_data) begin
      addr_q <= addr_q + AW'(1);   // wraps past the top address
      rem_q  <= rem_q - LW'(1);
    end
  end

`ifdef DUMP_CSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (accept)       sum_q <= '0;
      else if (ld_data) sum_q <= sum_q + mem_dat;

      if ((ld_data && last_word) || (state_q == WAIT_DONE && done && rem_zero))
        pend_q <= 1'b1;
      else if (ld_csum)
        pend_q <= 1'b0;
    end
  end
`endif

  assign mem_addr = addr_q;

  dump_out_reg #(.DW(DW)) u_out (
    .clk    (clk),
    .reset  (reset),
    .load_i (ld),
    .clr_i  (clr),
    .data_i (ld_dat),
    .last_i (ld_last),
    .valid_o(out_valid),
    .data_o (out_data),
    .last_o (out_last)
  );

endmodule

// File: tb/tb_result_dump.sv
module tb_result_dump;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_dat;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       finished;

  logic [7:0] mem [256];
  assign mem_dat = mem[mem_addr];

  result_dump dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .length(length), .req(req), .done(done), .mem_addr(mem_addr),
    .mem_dat(mem_dat), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .finished(finished)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // cycle counter (changes at posedge, stable when sampled at negedge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // core model: done drops on req, rises core_dly cycles later
  int core_dly = 5;
  int core_cnt = 0;
  int done_cyc = 0;
  initial begin
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (req) begin
        done = 1'b0;
        core_cnt = core_dly;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          done = 1'b1;
          done_cyc = cyc;
        end
      end
    end
  end

  // ready driver: updates just after posedge so it is stable at negedge
  int         rdy_mode = 0;
  logic [3:0] rdy_pat  = 4'b1001;   // 1,0,0,1 read from bit 0 upward
  int         rdy_idx  = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        out_ready = rdy_pat[rdy_idx % 4];
        rdy_idx++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // scoreboard monitor
  logic [8:0] exp_q [$];
  int   req_cnt = 0, fin_cnt = 0, xfer_cnt = 0;
  int   fin_cyc = 0, first_cyc = -1, last_cyc = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req)      req_cnt++;
        if (finished) begin fin_cnt++; fin_cyc = cyc; end
        if (prev_stall) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_beat", {23'd0, out_last, out_data}, {23'd0, prev_beat});
        end
        if (out_valid && out_ready) begin
          xfer_cnt++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0)
            chk("extra_beat", {23'd0, out_last, out_data}, 32'h1ff_ffff);
          else
            chk("beat", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = {out_last, out_data};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // push expected beats for a dump of len words from a
  task automatic push_exp(input logic [7:0] a, input logic [8:0] len, output int nb);
    int         n;
    logic [7:0] s;
    logic [7:0] ad;
    n = (len > 9'd256) ? 256 : int'(len);
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      ad = a + 8'(i);
      s  = s + mem[ad];
`ifdef DUMP_CSUM_EN
      exp_q.push_back({1'b0, mem[ad]});
`else
      exp_q.push_back({(i == n - 1), mem[ad]});
`endif
    end
`ifdef DUMP_CSUM_EN
    exp_q.push_back({1'b1, s});
    nb = n + 1;
`else
    nb = n;
`endif
  endtask

  task automatic run(input logic [7:0] a, input logic [8:0] len, input int dly,
                     input int rmode, input bit dup, input bit timing);
    int nb, r0, f0, t;
    push_exp(a, len, nb);
    core_dly  = dly;
    rdy_mode  = rmode;
    rdy_idx   = 0;
    r0        = req_cnt;
    f0        = fin_cnt;
    first_cyc = -1;
    @(negedge clk);
    start = 1'b1; start_addr = a; length = len;
    @(negedge clk);
    start = 1'b0; start_addr = ~a; length = 9'd7;
    if (dup) begin
      repeat (2) @(negedge clk);
      chk("busy_wait", {31'd0, busy}, 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (fin_cnt == f0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("fin_once", fin_cnt - f0, 1);
    chk("req_once", req_cnt - r0, 1);
    chk("q_empty", exp_q.size(), 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    if (nb > 0) chk("fin_after_last", fin_cyc - last_cyc, 1);
    if (timing) begin
      chk("first_lat", first_cyc - done_cyc, 2);
      chk("burst", last_cyc - first_cyc, nb - 1);
    end
    if (len == 9'd0) begin
`ifdef DUMP_CSUM_EN
      chk("len0_fin", fin_cyc - done_cyc, 3);
`else
      chk("len0_fin", fin_cyc - done_cyc, 1);
`endif
    end
    exp_q.delete();
  endtask

  initial begin
    int nb, r0, t;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    mem[8'h40] = 8'h80; mem[8'h41] = 8'h90; mem[8'h42] = 8'h10;

    reset = 1'b1; start = 1'b0; start_addr = '0; length = '0;
    #12;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fin", {31'd0, finished}, 0);
    chk("rst_addr", {24'd0, mem_addr}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_req_after_rst", req_cnt, 0);

    run(8'h10, 9'd4,   5, 0, 1'b0, 1'b1);  // basic burst
    run(8'h10, 9'd4,   5, 1, 1'b0, 1'b0);  // stalls
    run(8'hFE, 9'd4,   4, 0, 1'b0, 1'b1);  // address wrap
    run(8'h20, 9'd0,   5, 0, 1'b0, 1'b0);  // empty window
    run(8'h40, 9'd3,   6, 0, 1'b0, 1'b1);  // checksum overflow pattern
    run(8'h30, 9'd256, 3, 0, 1'b0, 1'b1);  // full memory
    run(8'h05, 9'd300, 3, 1, 1'b0, 1'b0);  // clamp to 256
    run(8'h60, 9'd5,   7, 0, 1'b1, 1'b1);  // start while busy ignored

    // reset mid-dump after 2 of 6 beats
    push_exp(8'h80, 9'd6, nb);
    core_dly = 4; rdy_mode = 0;
    t = xfer_cnt;
    @(negedge clk);
    start = 1'b1; start_addr = 8'h80; length = 9'd6;
    @(negedge clk);
    start = 1'b0;
    r0 = 0;
    while (xfer_cnt < t + 2 && r0 < 200) begin
      @(negedge clk);
      r0++;
    end
    chk("pre_rst_beats", xfer_cnt - t, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    r0 = req_cnt;
    repeat (4) @(negedge clk);
    chk("no_refire", req_cnt - r0, 0);
    chk("idle_after_rst", {31'd0, busy}, 0);
    run(8'h80, 9'd6, 4, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
